// File: rtl/qu_uop_pkg.sv
// rtl/qu_uop_pkg.sv - shared micro-op and issue-queue entry types
package qu_uop;

    localparam int PHY_RF_ADDR_WIDTH = 6;
    localparam int IQ_DEPTH          = 8;

    typedef enum logic [1:0] {
        OPT_INT  = 2'd0,
        OPT_CONT = 2'd1,
        OPT_MEM  = 2'd2,
        OPT_FP   = 2'd3
    } optype_e;

    typedef struct packed {
        optype_e                        optype;
        logic [5:0]                     opcode;
        logic [PHY_RF_ADDR_WIDTH-1:0]   rd;
        logic [PHY_RF_ADDR_WIDTH-1:0]   rs1;
        logic                           rs1_valid;
        logic [PHY_RF_ADDR_WIDTH-1:0]   rs2;
        logic                           rs2_valid;
        logic [11:0]                    imm;
    } uop_t;

    typedef struct packed {
        logic   valid;
        logic   rs1_rdy;
        logic   rs2_rdy;
        uop_t   uop;
    } iq_entry_t;

    // An operand the uop does not read never blocks issue.
    function automatic logic operand_ok(input logic used, input logic rdy);
        return !used || rdy;
    endfunction

endpackage

// File: rtl/qu_prio_enc.sv
// rtl/qu_prio_enc.sv - lowest-index-first one-hot and index picker
module qu_prio_enc #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] i_req,
    output logic             o_found,
    output logic [WIDTH-1:0] o_onehot,
    output logic [IDX_W-1:0] o_idx
);

    assign o_found = |i_req;

    // Scan from the top down so the lowest requesting index wins.
    always_comb begin
        o_idx    = '0;
        o_onehot = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx       = IDX_W'(i);
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qu_int_issue_queue.sv
// rtl/qu_int_issue_queue.sv - integer/control issue queue with writeback wakeup
module qu_int_issue_queue
    import qu_uop::*;
#(
    parameter int DEPTH     = IQ_DEPTH,
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  uop_t                          in_uop,
    input  logic                          in_rs1_rdy,
    input  logic                          in_rs2_rdy,
    input  logic                          wb_valid,
    input  logic [PHY_RF_ADDR_WIDTH-1:0]  wb_tag,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output uop_t                          issue_uop,
    output logic [CNT_WIDTH-1:0]          count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    iq_entry_t              r_entries [DEPTH];
    logic [CNT_WIDTH-1:0]   r_count;

    logic [DEPTH-1:0]       w_free;
    logic [DEPTH-1:0]       w_elig;
    logic                   w_free_found;
    logic [DEPTH-1:0]       w_free_oh;
    logic [IDX_W-1:0]       w_free_idx_unused;
    logic                   w_iss_found;
    logic [DEPTH-1:0]       w_iss_oh;
    logic [IDX_W-1:0]       w_iss_idx;
    logic                   w_enq;
    logic                   w_deq;
    logic                   w_in_rs1_rdy;
    logic                   w_in_rs2_rdy;

    always_comb begin
        w_free = '0;
        w_elig = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_free[i] = !r_entries[i].valid;
            w_elig[i] = r_entries[i].valid
                      && operand_ok(r_entries[i].uop.rs1_valid, r_entries[i].rs1_rdy)
                      && operand_ok(r_entries[i].uop.rs2_valid, r_entries[i].rs2_rdy);
        end
    end

    qu_prio_enc #(.WIDTH(DEPTH), .IDX_W(IDX_W)) u_free_pick (
        .i_req    (w_free),
        .o_found  (w_free_found),
        .o_onehot (w_free_oh),
        .o_idx    (w_free_idx_unused)
    );

    qu_prio_enc #(.WIDTH(DEPTH), .IDX_W(IDX_W)) u_issue_pick (
        .i_req    (w_elig),
        .o_found  (w_iss_found),
        .o_onehot (w_iss_oh),
        .o_idx    (w_iss_idx)
    );

    // Occupancy comes from the registered count only, so an issue this
    // cycle never opens a slot for an enqueue in the same cycle.
    assign in_ready    = (r_count < CNT_WIDTH'(DEPTH));
    assign count       = r_count;
    assign issue_valid = w_iss_found;

    always_comb begin
        issue_uop = '0;
        if (w_iss_found) begin
            issue_uop = r_entries[w_iss_idx].uop;
        end
    end

    assign w_enq        = in_valid && in_ready && w_free_found && !flush;
    assign w_deq        = w_iss_found && issue_ready && !flush;
    assign w_in_rs1_rdy = in_rs1_rdy || (wb_valid && (wb_tag == in_uop.rs1));
    assign w_in_rs2_rdy = in_rs2_rdy || (wb_valid && (wb_tag == in_uop.rs2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].valid   <= 1'b0;
                r_entries[i].rs1_rdy <= 1'b0;
                r_entries[i].rs2_rdy <= 1'b0;
                r_entries[i].uop     <= '0;
            end
            r_count <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].valid <= 1'b0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                // Tag match alone wakes the operand; rs*_valid only matters at select.
                if (r_entries[i].valid && wb_valid) begin
                    if (r_entries[i].uop.rs1 == wb_tag) r_entries[i].rs1_rdy <= 1'b1;
                    if (r_entries[i].uop.rs2 == wb_tag) r_entries[i].rs2_rdy <= 1'b1;
                end
                if (w_deq && w_iss_oh[i]) begin
                    r_entries[i].valid <= 1'b0;
                end
                if (w_enq && w_free_oh[i]) begin
                    r_entries[i].valid   <= 1'b1;
                    r_entries[i].uop     <= in_uop;
                    r_entries[i].rs1_rdy <= w_in_rs1_rdy;
                    r_entries[i].rs2_rdy <= w_in_rs2_rdy;
                end
            end
            r_count <= r_count + CNT_WIDTH'(w_enq) - CNT_WIDTH'(w_deq);
        end
    end

endmodule

// File: tb/tb_qu_int_issue_queue.sv
// tb/tb_qu_int_issue_queue.sv - randomized and directed bench against a slot-array model
module tb_qu_int_issue_queue;
    import qu_uop::*;

    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         flush;
    logic                         in_valid;
    logic                         in_ready;
    uop_t                         in_uop;
    logic                         in_rs1_rdy;
    logic                         in_rs2_rdy;
    logic                         wb_valid;
    logic [PHY_RF_ADDR_WIDTH-1:0] wb_tag;
    logic                         issue_valid;
    logic                         issue_ready;
    uop_t                         issue_uop;
    logic [CW-1:0]                count;

    int checks = 0;
    int errors = 0;

    bit   m_v  [DEPTH];
    uop_t m_u  [DEPTH];
    bit   m_r1 [DEPTH];
    bit   m_r2 [DEPTH];

    qu_int_issue_queue #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_uop      (in_uop),
        .in_rs1_rdy  (in_rs1_rdy),
        .in_rs2_rdy  (in_rs2_rdy),
        .wb_valid    (wb_valid),
        .wb_tag      (wb_tag),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_uop   (issue_uop),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_elig(input int i);
        return m_v[i] && (!m_u[i].rs1_valid || m_r1[i]) && (!m_u[i].rs2_valid || m_r2[i]);
    endfunction

    function automatic int m_sel();
        for (int i = 0; i < DEPTH; i++) if (m_elig(i)) return i;
        return -1;
    endfunction

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (m_v[i]) n++;
        return n;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_v[i] = 1'b0; m_r1[i] = 1'b0; m_r2[i] = 1'b0; m_u[i] = '0;
        end
    endfunction

    function automatic uop_t mk_uop(input int rs1, input bit v1, input int rs2, input bit v2, input int id);
        uop_t u;
        u.optype    = id[0] ? OPT_CONT : OPT_INT;
        u.opcode    = 6'(id);
        u.rd        = 6'(id + 1);
        u.rs1       = 6'(rs1);
        u.rs1_valid = v1;
        u.rs2       = 6'(rs2);
        u.rs2_valid = v2;
        u.imm       = 12'(id * 37);
        return u;
    endfunction

    function automatic uop_t rand_uop();
        return mk_uop(int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)),
                      1'($urandom), int'($urandom_range(0, 4095)));
    endfunction

    task automatic check_outputs();
        int s = m_sel();
        check("issue_valid", {63'd0, issue_valid}, {63'd0, s >= 0});
        if (s >= 0) check("issue_uop", 64'(issue_uop), 64'(m_u[s]));
        check("count", 64'(count), 64'(m_cnt()));
        check("in_ready", {63'd0, in_ready}, {63'd0, m_cnt() < DEPTH});
    endtask

    task automatic model_update();
        int fs = -1;
        int s;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
            return;
        end
        if (in_valid && m_cnt() < DEPTH) begin
            for (int i = DEPTH - 1; i >= 0; i--) if (!m_v[i]) fs = i;
        end
        s = m_sel();
        if (s >= 0 && issue_ready) m_v[s] = 1'b0;
        if (wb_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (m_v[i] && m_u[i].rs1 == wb_tag) m_r1[i] = 1'b1;
                if (m_v[i] && m_u[i].rs2 == wb_tag) m_r2[i] = 1'b1;
            end
        end
        if (fs >= 0) begin
            m_v[fs]  = 1'b1;
            m_u[fs]  = in_uop;
            m_r1[fs] = in_rs1_rdy || (wb_valid && wb_tag == in_uop.rs1);
            m_r2[fs] = in_rs2_rdy || (wb_valid && wb_tag == in_uop.rs2);
        end
    endtask

    // Called at a negedge: drive, check the current state, advance one edge.
    task automatic cycle(input bit iv, input uop_t u, input bit r1, input bit r2,
                         input bit wv, input int tag, input bit ir, input bit fl);
        in_valid    = iv;
        in_uop      = u;
        in_rs1_rdy  = r1;
        in_rs2_rdy  = r2;
        wb_valid    = wv;
        wb_tag      = 6'(tag);
        issue_ready = ir;
        flush       = fl;
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle(input bit ir);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 63, ir, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_issue_valid", {63'd0, issue_valid}, 64'd0);
        check("rst_issue_uop", 64'(issue_uop), 64'd0);
        m_clear();
        in_valid = 1'b0; issue_ready = 1'b0; flush = 1'b0; wb_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rand_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            cycle(($urandom_range(0, 3) != 0), rand_uop(), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
        end
    endtask

    initial begin
        uop_t u;
        uop_t u2;
        uop_t u5;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_uop = '0; in_rs1_rdy = 1'b0;
        in_rs2_rdy = 1'b0; wb_valid = 1'b0; wb_tag = '0; issue_ready = 1'b0;
        m_clear();
        repeat (2) @(negedge clk);
        check("init_count", 64'(count), 64'd0);
        check("init_issue_valid", {63'd0, issue_valid}, 64'd0);
        rst = 1'b0;

        // Ready-operand uop issues the next cycle and drains.
        u = mk_uop(1, 1'b0, 2, 1'b0, 1);
        cycle(1'b1, u, 1'b0, 1'b0, 1'b0, 63, 1'b0, 1'b0);
        check("lat1_valid", {63'd0, issue_valid}, 64'd1);
        check("lat1_uop", 64'(issue_uop), 64'(u));
        check("lat1_count", 64'(count), 64'd1);
        idle(1'b1);
        check("lat1_drain", 64'(count), 64'd0);

        // Wakeup in cycle 3 makes the entry issuable in cycle 4.
        u = mk_uop(5, 1'b1, 0, 1'b0, 2);
        cycle(1'b1, u, 1'b0, 1'b0, 1'b0, 63, 1'b0, 1'b0);
        check("wake_c1", {63'd0, issue_valid}, 64'd0);
        idle(1'b0);
        check("wake_c2", {63'd0, issue_valid}, 64'd0);
        idle(1'b0);
        check("wake_c3", {63'd0, issue_valid}, 64'd0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 5, 1'b0, 1'b0);
        check("wake_c4", {63'd0, issue_valid}, 64'd1);
        idle(1'b1);

        // Same-cycle wakeup captured at enqueue.
        u = mk_uop(9, 1'b1, 0, 1'b0, 3);
        cycle(1'b1, u, 1'b0, 1'b0, 1'b1, 9, 1'b0, 1'b0);
        check("enq_wake", {63'd0, issue_valid}, 64'd1);
        idle(1'b1);

        // Full queue rejects an enqueue even while an issue frees a slot.
        for (int k = 0; k < DEPTH; k++) cycle(1'b1, mk_uop(0, 1'b0, 0, 1'b0, k + 16), 1'b1, 1'b1, 1'b0, 63, 1'b0, 1'b0);
        check("full_count", 64'(count), 64'd8);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        cycle(1'b1, mk_uop(0, 1'b0, 0, 1'b0, 40), 1'b1, 1'b1, 1'b0, 63, 1'b1, 1'b0);
        check("full_iss_count", 64'(count), 64'd7);
        check("full_iss_ready", {63'd0, in_ready}, 64'd1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 63, 1'b0, 1'b1);

        // Entries 2 and 5 eligible; stalled selection holds entry 2.
        u2 = '0; u5 = '0;
        for (int k = 0; k < 6; k++) begin
            u = mk_uop(60, (k != 2 && k != 5), 0, 1'b0, k + 32);
            if (k == 2) u2 = u;
            if (k == 5) u5 = u;
            cycle(1'b1, u, 1'b0, 1'b0, 1'b0, 63, 1'b0, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            check("hold_uop", 64'(issue_uop), 64'(u2));
            idle(1'b0);
        end
        idle(1'b1);
        check("next_uop", 64'(issue_uop), 64'(u5));
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 63, 1'b0, 1'b1);

        // Flush beats a same-cycle enqueue and issue.
        for (int k = 0; k < 4; k++) cycle(1'b1, mk_uop(0, 1'b0, 0, 1'b0, k + 48), 1'b0, 1'b0, 1'b0, 63, 1'b0, 1'b0);
        check("pre_flush_count", 64'(count), 64'd4);
        cycle(1'b1, mk_uop(0, 1'b0, 0, 1'b0, 52), 1'b1, 1'b1, 1'b0, 63, 1'b1, 1'b1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_issue_valid", {63'd0, issue_valid}, 64'd0);

        rand_cycles(300);
        do_reset();
        rand_cycles(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qu_int_issue_queue.md
QU_INT_ISSUE_QUEUE -- requirements
Module: qu_int_issue_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 8, number of entries (power of two, 2..32).
REQ-002 SHALL have parameter: CNT_WIDTH, $clog2(DEPTH)+1, width of occupancy count.
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port: flush  in  1  discard all entries.
REQ-006 SHALL have port: in_valid  in  1  rename stage offers a uop.
REQ-007 SHALL have port: in_ready  out  1  queue accepts the offered uop.
REQ-008 SHALL have port: in_uop  in  uop_t  integer/control micro-op (optype INT or CONT only).
REQ-009 SHALL have port: in_rs1_rdy  in  1  rs1 physical register already available.
REQ-010 SHALL have port: in_rs2_rdy  in  1  rs2 physical register already available.
REQ-011 SHALL have port: wb_valid  in  1  writeback broadcast valid.
REQ-012 SHALL have port: wb_tag  in  PHY_RF_ADDR_WIDTH  physical register being written.
REQ-013 SHALL have port: issue_valid  out  1  a ready uop is presented to the luftALU.
REQ-014 SHALL have port: issue_ready  in  1  ALU accepts the presented uop.
REQ-015 SHALL have port: issue_uop  out  uop_t  selected uop, unmodified from enqueue.
REQ-016 SHALL have port: count  out  CNT_WIDTH  number of valid entries.

Function
REQ-017 SHALL hold per entry: valid, uop, rs1_rdy, rs2_rdy.
REQ-018 SHALL treat an entry as eligible when valid and (!rs1_valid or rs1_rdy) and (!rs2_valid or rs2_rdy).
REQ-019 SHALL drive in_ready = (count < DEPTH), from registered state only; same-cycle issue SHALL NOT free a slot for same-cycle enqueue.
REQ-020 SHALL enqueue on in_valid && in_ready into the lowest-index invalid entry.
REQ-021 SHALL set enqueued rs1_rdy = in_rs1_rdy OR (wb_valid && wb_tag == in_uop.rs1); same rule for rs2.
REQ-022 SHALL set rs1_rdy/rs2_rdy of every valid entry whose rs1/rs2 equals wb_tag when wb_valid; the operand-valid bit SHALL NOT gate the match.
REQ-023 SHALL drive issue_valid combinationally = any eligible entry; issue_uop = uop of lowest-index eligible entry.
REQ-024 SHALL invalidate the selected entry on issue_valid && issue_ready; issue_uop SHALL be stable while issue_valid && !issue_ready unless a lower-index entry becomes eligible.
REQ-025 SHALL give minimum latency of one cycle: uop enqueued in cycle N with ready operands is issuable in N+1; wakeup in cycle N makes an entry issuable in N+1.
REQ-026 SHALL update count as count + enq - deq, handling simultaneous enqueue and issue (net zero).
REQ-027 SHALL, on flush, clear all valid bits and count at the next edge; flush SHALL override same-cycle enqueue and issue; issue_valid SHALL still reflect current state in the flush cycle.
REQ-028 SHALL drop wakeups with wb_valid=0 and retain no wakeup history.

Reset
REQ-029 SHALL on rst clear all valid, rs1_rdy and rs2_rdy bits immediately, giving count=0, in_ready=1, issue_valid=0, issue_uop=0.
REQ-030 SHALL abandon an in-flight handshake when rst asserts mid-cycle; no entry survives.

Structure
REQ-031 SHALL place the entry typedef (iq_entry_t: valid, rs1_rdy, rs2_rdy, uop_t) and default DEPTH in package qu_uop.
REQ-032 SHALL use one sub-module qu_prio_enc (parameterised lowest-index-first one-hot/index picker) for both free-slot allocation and issue selection.

Verification
REQ-033 SHALL cover: enqueue uop with rs1_valid=rs2_valid=0 in cycle 0 -> issue_valid=1 in cycle 1, issue_uop equal to input, count 1->0 after handshake.
REQ-034 SHALL cover: enqueue uop rs1=p5 not ready; wb_valid=1, wb_tag=5 in cycle 3 -> issue_valid=0 in cycles 1-3, =1 in cycle 4.
REQ-035 SHALL cover: same-cycle enqueue of rs1=p9 with wb_tag=9 and in_rs1_rdy=0 -> issuable next cycle.
REQ-036 SHALL cover: fill 8 entries -> in_ready=0, count=8; issue one with enqueue attempted same cycle -> enqueue rejected, count=7, in_ready=1 next cycle.
REQ-037 SHALL cover: entries 2 and 5 eligible with issue_ready=0 for 3 cycles -> issue_uop stays entry 2; then handshake -> entry 5 presented next cycle.
REQ-038 SHALL cover: flush together with in_valid and issue handshake at count=4 -> count=0, issue_valid=0 next cycle; rst asserted mid-run -> outputs at reset values immediately.
